// File: rtl/ctrl_if.sv
// Thumb fetch-stage controller: PC, imem req/ack handshake, branch redirect and a one-entry skid buffer.
// Optional CTRL_IF_FLUSH_CNT_EN adds a saturating o_flush_cnt of redirect cycles.
module ctrl_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [15:0] NOP_INSN = 16'hBF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_branch_met,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_data,
    output logic [15:0] o_ir_id,
    output logic [31:0] o_pc_id,
`ifdef CTRL_IF_FLUSH_CNT_EN
    output logic [15:0] o_flush_cnt,
`endif
    output logic        o_valid_id
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [31:0] pcid_q, pcid_d;
    logic        vld_q, vld_d;
    logic [15:0] skid_ir_q, skid_ir_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_vld_q, skid_vld_d;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:1], 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            ir_q       <= NOP_INSN;
            pcid_q     <= 32'h0;
            vld_q      <= 1'b0;
            skid_ir_q  <= NOP_INSN;
            skid_pc_q  <= 32'h0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pcid_q     <= pcid_d;
            vld_q      <= vld_d;
            skid_ir_q  <= skid_ir_d;
            skid_pc_q  <= skid_pc_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        pcid_d     = pcid_q;
        vld_d      = vld_q;
        skid_ir_d  = skid_ir_q;
        skid_pc_d  = skid_pc_q;
        skid_vld_d = skid_vld_q;

        if (i_branch_met) begin
            // Redirect beats stall, ack and a pending skid entry.
            state_d    = FETCH;
            pc_d       = {i_branch_target[31:1], 1'b0};
            ir_d       = NOP_INSN;
            vld_d      = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (i_stall) begin
                        if (i_imem_ack) begin
                            skid_ir_d  = i_imem_data;
                            skid_pc_d  = pc_q;
                            skid_vld_d = 1'b1;
                            pc_d       = pc_q + 32'd2;
                            state_d    = HOLD;
                        end
                    end else if (i_imem_ack) begin
                        ir_d   = i_imem_data;
                        pcid_d = pc_q;
                        vld_d  = 1'b1;
                        pc_d   = pc_q + 32'd2;
                    end else begin
                        ir_d  = NOP_INSN;
                        vld_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        ir_d       = skid_ir_q;
                        pcid_d     = skid_pc_q;
                        vld_d      = 1'b1;
                        skid_vld_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_imem_req  = (state_q == FETCH);
    assign o_imem_addr = pc_q;
    assign o_ir_id     = ir_q;
    assign o_pc_id     = pcid_q;
    assign o_valid_id  = vld_q;

`ifdef CTRL_IF_FLUSH_CNT_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (i_branch_met && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flush_cnt_q <= 16'h0;
        else      flush_cnt_q <= flush_cnt_d;
    end

    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_if.sv
// Directed bench for ctrl_if: reset, streaming, bubbles, stall/skid, branches, PC wrap, async reset.
module tb_ctrl_if;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall, i_branch_met, i_imem_ack;
    logic [31:0] i_branch_target;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [15:0] i_imem_data;
    logic [15:0] o_ir_id;
    logic [31:0] o_pc_id;
    logic        o_valid_id;
    logic        use_ovr;
    logic [15:0] ovr_data;
`ifdef CTRL_IF_FLUSH_CNT_EN
    logic [15:0] o_flush_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory model: each halfword holds 0xD000 | addr[11:0], unless overridden.
    assign i_imem_data = use_ovr ? ovr_data : {4'hD, o_imem_addr[11:0]};

    ctrl_if #(.RESET_PC(32'h100), .NOP_INSN(16'hBF00)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_branch_met(i_branch_met),
        .i_branch_target(i_branch_target), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .o_ir_id(o_ir_id), .o_pc_id(o_pc_id),
`ifdef CTRL_IF_FLUSH_CNT_EN
        .o_flush_cnt(o_flush_cnt),
`endif
        .o_valid_id(o_valid_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [15:0] ir, input logic [31:0] pc, input logic v);
        chk({tag, ".ir"}, {16'h0, o_ir_id}, {16'h0, ir});
        if (v) chk({tag, ".pc"}, o_pc_id, pc);
        chk({tag, ".vld"}, {31'h0, o_valid_id}, {31'h0, v});
    endtask

    initial begin
        rst = 1'b0; i_stall = 1'b0; i_branch_met = 1'b0; i_branch_target = 32'h0;
        i_imem_ack = 1'b1; use_ovr = 1'b0; ovr_data = 16'h0;
        step(); step();
        chk("rst.req", {31'h0, o_imem_req}, 32'h0);
        chk("rst.addr", o_imem_addr, 32'h100);
        chk("rst.pcid", o_pc_id, 32'h0);
        chk_id("rst", 16'hBF00, 32'h0, 1'b0);

        rst = 1'b1;
        step();
        chk("rel.req", {31'h0, o_imem_req}, 32'h1);
        chk("rel.addr", o_imem_addr, 32'h100);
        chk("rel.vld", {31'h0, o_valid_id}, 32'h0);
        step();
        chk_id("s0", 16'hD100, 32'h100, 1'b1);
        chk("s0.addr", o_imem_addr, 32'h102);
        step();
        chk_id("s1", 16'hD102, 32'h102, 1'b1);
        chk("s1.addr", o_imem_addr, 32'h104);
        step();
        chk_id("s2", 16'hD104, 32'h104, 1'b1);

        // Three wait cycles: bubbles, address held.
        i_imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_id("bub", 16'hBF00, 32'h0, 1'b0);
            chk("bub.addr", o_imem_addr, 32'h106);
        end
        i_imem_ack = 1'b1;
        step();
        chk_id("aft_bub", 16'hD106, 32'h106, 1'b1);
        chk("aft_bub.addr", o_imem_addr, 32'h108);

        // Four-cycle stall while 0x4770 is acked at 0x108.
        i_stall = 1'b1; use_ovr = 1'b1; ovr_data = 16'h4770;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_id("stall", 16'hD106, 32'h106, 1'b1);
            chk("stall.req", {31'h0, o_imem_req}, 32'h0);
            chk("stall.addr", o_imem_addr, 32'h10A);
        end
        i_stall = 1'b0; use_ovr = 1'b0;
        step();
        chk_id("unstall", 16'h4770, 32'h108, 1'b1);
        chk("unstall.req", {31'h0, o_imem_req}, 32'h1);
        step();
        chk_id("post_unstall", 16'hD10A, 32'h10A, 1'b1);

        // Branch coincident with an ack; target bit 0 dropped.
        i_branch_met = 1'b1; i_branch_target = 32'h201;
        step();
        i_branch_met = 1'b0;
        chk_id("br1", 16'hBF00, 32'h0, 1'b0);
        chk("br1.addr", o_imem_addr, 32'h200);
        step();
        chk_id("br1.tgt", 16'hD200, 32'h200, 1'b1);

        // Branch while holding a skid entry.
        i_stall = 1'b1;
        step();
        chk("hold.req", {31'h0, o_imem_req}, 32'h0);
        i_branch_met = 1'b1; i_branch_target = 32'h300;
        step();
        i_branch_met = 1'b0; i_stall = 1'b0;
        chk_id("br2", 16'hBF00, 32'h0, 1'b0);
        chk("br2.addr", o_imem_addr, 32'h300);
        step();
        chk_id("br2.tgt", 16'hD300, 32'h300, 1'b1);

        // PC wrap.
        i_branch_met = 1'b1; i_branch_target = 32'hFFFF_FFFE;
        step();
        i_branch_met = 1'b0;
        chk("wrap.addr0", o_imem_addr, 32'hFFFF_FFFE);
        step();
        chk_id("wrap", 16'hDFFE, 32'hFFFF_FFFE, 1'b1);
        chk("wrap.addr", o_imem_addr, 32'h0);
`ifdef CTRL_IF_FLUSH_CNT_EN
        chk("flush3", {16'h0, o_flush_cnt}, 32'd3);
`endif

        // Back-to-back branches: last wins.
        i_branch_met = 1'b1; i_branch_target = 32'h400;
        step();
        chk("bb.addr0", o_imem_addr, 32'h400);
        i_branch_target = 32'h500;
        step();
        i_branch_met = 1'b0;
        chk("bb.addr1", o_imem_addr, 32'h500);
        chk_id("bb", 16'hBF00, 32'h0, 1'b0);
        step();
        chk_id("bb.tgt", 16'hD500, 32'h500, 1'b1);
`ifdef CTRL_IF_FLUSH_CNT_EN
        chk("flush5", {16'h0, o_flush_cnt}, 32'd5);
`endif

        // Async reset mid-fetch, between edges.
        #2 rst = 1'b0;
        #1;
        chk("arst.req", {31'h0, o_imem_req}, 32'h0);
        chk("arst.addr", o_imem_addr, 32'h100);
        chk("arst.pcid", o_pc_id, 32'h0);
        chk_id("arst", 16'hBF00, 32'h0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("arst.rel.vld", {31'h0, o_valid_id}, 32'h0);
        step();
        chk_id("arst.first", 16'hD100, 32'h100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ctrl_if.md
# ctrl_if

Fetch-stage controller for the 16-bit Thumb pipeline. It consumes the branch decision produced at the end of EX and drives instruction memory. It keeps the program counter, runs a req/ack fetch handshake, and presents one instruction per cycle to decode. On a taken branch it redirects fetch and squashes the wrong-path instruction. During pipeline stalls it holds the decode-stage outputs without losing a returned fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (bit 0 ignored)
- NOP_INSN, 16'hBF00, bubble encoding driven to decode
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- i_stall  input  1  downstream stall; hold decode outputs
- i_branch_met  input  1  taken branch resolved in EX this cycle
- i_branch_target  input  32  branch destination address
- o_imem_req  output  1  fetch request
- o_imem_addr  output  32  halfword fetch address, bit 0 always 0
- i_imem_ack  input  1  i_imem_data valid for the o_imem_addr presented in the same cycle
- i_imem_data  input  16  fetched instruction
- o_ir_id  output  16  instruction to decode
- o_pc_id  output  32  address of o_ir_id
- o_valid_id  output  1  o_ir_id is a real instruction, not a bubble

## Operation
- State machine: IDLE, FETCH, HOLD.
  - IDLE → FETCH unconditionally.
  - FETCH → HOLD on ack while i_stall=1.
  - HOLD → FETCH when i_stall=0.
  - Any state → FETCH on i_branch_met.
- Reset values while rst=0:
  - state IDLE, pc=RESET_PC with bit 0 cleared.
  - o_imem_req=0, o_imem_addr=pc.
  - o_ir_id=NOP_INSN, o_pc_id=0, o_valid_id=0, skid buffer empty.
- Outputs by state:
  - FETCH: o_imem_req=1. o_imem_addr=pc, which changes only after an accepted ack or a redirect.
  - IDLE and HOLD: o_imem_req=0.
- FETCH, ack, no stall:
  - o_ir_id<=i_imem_data, o_pc_id<=pc, o_valid_id<=1.
  - pc<=pc+2, 32-bit wrap (32'hFFFF_FFFE+2 → 0).
- FETCH, no ack, no stall: o_ir_id<=NOP_INSN, o_valid_id<=0 (bubble). pc unchanged.
- i_stall=1: o_ir_id, o_pc_id and o_valid_id hold.
  - In FETCH with ack: data and pc go into the skid buffer, pc<=pc+2, state → HOLD.
  - In FETCH without ack: the request stays asserted.
- HOLD and i_stall=0: skid-buffer contents move to the decode outputs, o_valid_id<=1, state → FETCH.
- Branch redirect (i_branch_met=1) has highest priority, over stall, ack and HOLD:
  - pc<=i_branch_target with bit 0 cleared.
  - o_ir_id<=NOP_INSN, o_valid_id<=0.
  - Skid buffer discarded; any same-cycle ack discarded.
  - State → FETCH.
- Back-to-back branches: the last redirect wins. Each redirect inserts at least one bubble.
- Asynchronous reset mid-fetch: outputs take reset values immediately. No ack is consumed until the first FETCH cycle after reset release.

## Timing
- Reset release at edge R: o_imem_req=1 from R+1, first o_valid_id=1 at R+2 with zero-wait memory.
- Fetch latency: ack in cycle N → o_ir_id valid in cycle N+1.
- Sustained throughput: 1 instruction/cycle with ack held high.
- Branch penalty:
  - i_branch_met in cycle N → o_imem_addr=target in N+1, o_ir_id=NOP_INSN in N+1.
  - With ack in N+1, the target instruction is on o_ir_id in N+2.
- Stall release: buffered instruction on o_ir_id one cycle after i_stall falls. The next request is issued in that same cycle.

## Configuration
- CTRL_IF_FLUSH_CNT_EN defined:
  - Adds output o_flush_cnt (16 bits), reset 0.
  - Increments on every cycle with i_branch_met=1, saturating at 16'hFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset with RESET_PC=32'h100, ack tied high → o_imem_addr 0x100, 0x102, 0x104 on consecutive cycles; o_ir_id follows one cycle later with o_pc_id matching; o_valid_id=1 from R+2.
- ack low for 3 cycles mid-stream → 3 bubbles (NOP_INSN=16'hBF00, o_valid_id=0); o_imem_addr stable; no address skipped.
- i_stall=1 for 4 cycles while ack=1 with data 16'h4770 → decode outputs frozen; after stall release o_ir_id=16'h4770 once, followed by the next sequential fetch; no duplicate and no loss.
- i_branch_met=1 with target 32'h201 during an ack → acked data discarded; o_ir_id=NOP_INSN; next o_imem_addr=32'h200.
- Branch during HOLD with i_stall=1 → buffered instruction never reaches decode; fetch resumes at the target.
- pc=32'hFFFF_FFFE with ack → next o_imem_addr=0. With CTRL_IF_FLUSH_CNT_EN defined, 3 branches → o_flush_cnt=3.
